lsu_ram_port: RTL and testbench

- Load/store unit: the requester side of the word-addressed, byte-write-enabled data RAM port.
- Accepts CPU memory requests using RISC-V funct3 encoding and drives one RAM port (byte write enables, word address, write data).
- Consumes the RAM's 1-cycle registered read data, then aligns and sign/zero-extends the load result.
- Sits between the pipeline MEM stage and the data RAM.

---
 rtl/lsu_ram_port.sv | 267 ++++++++++++++++++++++++++
 tb/tb_lsu_ram_port.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_port.sv
// Load/store unit driving one word-addressed, byte-write-enabled RAM port with 1-cycle read latency.
// Optional macro LSU_MISALIGN_SPLIT_EN splits misaligned H/HU/W accesses into two word accesses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; also the cycle a response pulse is high
// ACCESS  | RAM port driven for word 0 (write, or read address)
// LWAIT   | aligned load: read data on mem_dout, extend and respond
// ERR     | illegal/misaligned request, respond with error
// ACCESS1 | split only: word 1 access, word 0 read data captured
// LWAIT1  | split only: word 1 read data on mem_dout, merge and respond
module lsu_ram_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_LWAIT   = 3'd2,
    S_ERR     = 3'd3
`ifdef LSU_MISALIGN_SPLIT_EN
    ,
    S_ACCESS1 = 3'd4,
    S_LWAIT1  = 3'd5
`endif
  } state_t;

  state_t state_q, state_d;

  logic              is_store_q, is_store_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        off_q, off_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_d;
  logic [31:0]       mem_din_d;
  logic              resp_valid_d, resp_err_d;
  logic [31:0]       resp_rdata_d;

  logic              illegal, misal;
  logic [3:0]        lane_mask, we_lo;
  logic [31:0]       din_rep;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [3:0]        hi_we_q, hi_we_d;
  logic [31:0]       hi_din_q, hi_din_d;
  logic [31:0]       w0_q, w0_d;
  logic [7:0]        mask8;
  logic [63:0]       data64;
  logic [31:0]       merged;
`endif

  function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] x);
    case (t)
      3'b000:  return {{24{x[7]}}, x[7:0]};
      3'b100:  return {24'd0, x[7:0]};
      3'b001:  return {{16{x[15]}}, x[15:0]};
      3'b101:  return {16'd0, x[15:0]};
      default: return x;
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE);
  // Gate the write strobe with reset so a reset cycle never commits a store.
  assign mem_we    = rst ? 4'b0000 : mem_we_q;

  always_comb begin
    illegal = (req_type == 3'b011) || (req_type[2:1] == 2'b11) || (req_type[2] && req_we);
    misal   = 1'b0;
    case (req_type[1:0])
      2'b00: begin
        lane_mask = 4'b0001;
        din_rep   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011;
        din_rep   = {2{req_wdata[15:0]}};
        misal     = req_addr[0];
      end
      default: begin
        lane_mask = 4'b1111;
        din_rep   = req_wdata;
        misal     = |req_addr[1:0];
      end
    endcase
    we_lo = lane_mask << req_addr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
    mask8  = {4'b0000, lane_mask} << req_addr[1:0];
    data64 = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
    case (off_q)
      2'd1:    merged = {mem_dout[7:0],  w0_q[31:8]};
      2'd2:    merged = {mem_dout[15:0], w0_q[31:16]};
      2'd3:    merged = {mem_dout[23:0], w0_q[31:24]};
      default: merged = w0_q;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      type_q     <= 3'd0;
      off_q      <= 2'd0;
      mem_we_q   <= 4'd0;
      mem_addr   <= '0;
      mem_din    <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      hi_we_q    <= 4'd0;
      hi_din_q   <= 32'd0;
      w0_q       <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      type_q     <= type_d;
      off_q      <= off_d;
      mem_we_q   <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_din    <= mem_din_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q    <= split_d;
      hi_we_q    <= hi_we_d;
      hi_din_q   <= hi_din_d;
      w0_q       <= w0_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            state_d = S_ERR;
          end else if (misal) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = S_ACCESS;
`else
            state_d = S_ERR;
`endif
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        state_d = is_store_q ? S_IDLE : S_LWAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) state_d = S_ACCESS1;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACCESS1: state_d = is_store_q ? S_IDLE : S_LWAIT1;
      S_LWAIT1:  state_d = S_IDLE;
`endif
      S_LWAIT:   state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_store_d   = is_store_q;
    type_d       = type_q;
    off_d        = off_q;
    mem_we_d     = 4'd0;
    mem_addr_d   = mem_addr;
    mem_din_d    = mem_din;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d      = split_q;
    hi_we_d      = hi_we_q;
    hi_din_d     = hi_din_q;
    w0_d         = w0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = req_we;
          type_d     = req_type;
          off_d      = req_addr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d = misal;
          if (!illegal) begin
            mem_addr_d = req_addr[ADDR_W-1:2];
            hi_we_d    = mask8[7:4];
            hi_din_d   = data64[63:32];
            if (req_we) begin
              mem_we_d  = misal ? mask8[3:0] : we_lo;
              mem_din_d = misal ? data64[31:0] : din_rep;
            end
          end
`else
          if (!illegal && !misal) begin
            mem_addr_d = req_addr[ADDR_W-1:2];
            if (req_we) begin
              mem_we_d  = we_lo;
              mem_din_d = din_rep;
            end
          end
`endif
        end
      end
      S_ACCESS: begin
        resp_valid_d = is_store_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        // Second word wraps naturally in the word-address width.
        if (split_q) begin
          resp_valid_d = 1'b0;
          mem_addr_d   = mem_addr + 1'b1;
          if (is_store_q) begin
            mem_we_d  = hi_we_q;
            mem_din_d = hi_din_q;
          end
        end
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACCESS1: begin
        w0_d         = mem_dout;
        resp_valid_d = is_store_q;
      end
      S_LWAIT1: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = extend(type_q, merged);
      end
`endif
      S_LWAIT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = extend(type_q, mem_dout >> {off_q, 3'b000});
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ram_port.sv
// Scoreboard bench for lsu_ram_port: expected responses and RAM writes are queued at stimulus
// time and popped when the DUT produces them. Build with LSU_MISALIGN_SPLIT_EN for the split variant.
module tb_lsu_ram_port;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  lsu_ram_port #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) ram[mem_addr[5:0]][8*i +: 8] <= mem_din[8*i +: 8];
    mem_dout <= ram[mem_addr[5:0]];
  end

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  resp_t re;
  wr_t   we_exp;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] bm [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        chk("ready_in_resp", {63'd0, req_ready}, 64'd1);
        if (rq.size() == 0) begin
          chk("unexp_resp", {63'd0, resp_valid}, 64'd0);
        end else begin
          re = rq.pop_front();
          chk({re.tag, "_err"}, {63'd0, resp_err}, {63'd0, re.err});
          chk({re.tag, "_rdata"}, {32'd0, resp_rdata}, {32'd0, re.rdata});
          chk({re.tag, "_lat"}, 64'(cyc - re.acc), 64'(re.lat));
        end
      end
      if (mem_we != 4'd0) begin
        if (wq.size() == 0) begin
          chk("unexp_we", {60'd0, mem_we}, 64'd0);
        end else begin
          we_exp = wq.pop_front();
          chk("wr_addr", {34'd0, mem_addr}, {34'd0, we_exp.addr});
          chk("wr_we", {60'd0, mem_we}, {60'd0, we_exp.we});
          chk("wr_din", {32'd0, mem_din}, {32'd0, we_exp.din});
        end
      end
    end
  end

  task automatic push_wr(input logic [29:0] a, input logic [3:0] w, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.we = w; e.din = d;
    wq.push_back(e);
  endtask

  task automatic issue(input string tag, input logic we, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic err, input logic [31:0] rd, input int lat);
    resp_t e;
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_ready_timeout"}, {63'd0, req_ready}, 64'd1);
    e.tag = tag; e.err = err; e.rdata = rd; e.lat = lat; e.acc = cyc + 1;
    rq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] t, input int a);
    logic [7:0] b0, b1, b2, b3;
    b0 = bm[a]; b1 = bm[a+1]; b2 = bm[a+2]; b3 = bm[a+3];
    case (t)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'd0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int waddr, o, ts;
    logic [31:0] wd;
    logic [2:0] t;
    for (int i = 0; i < 64; i++) ram[i] = 32'd0;
    for (int i = 0; i < 256; i++) bm[i] = 8'd0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0;
    req_addr = '0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("rst_mem_we", {60'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {34'd0, mem_addr}, 64'd0);
    chk("rst_mem_din", {32'd0, mem_din}, 64'd0);
    rst = 1'b0;

    push_wr(30'd4, 4'b1111, 32'hDEADBEEF);
    issue("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1);
    issue("lb13", 1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 32'hFFFFFFDE, 2);
    issue("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 32'h000000DE, 2);
    issue("lh10", 1'b0, 3'b001, 32'h10, 32'd0, 1'b0, 32'hFFFFBEEF, 2);
    issue("lhu12", 1'b0, 3'b101, 32'h12, 32'd0, 1'b0, 32'h0000DEAD, 2);
    issue("lw10", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 2);

    push_wr(30'd8, 4'b0010, 32'hABABABAB);
    issue("sb21", 1'b1, 3'b000, 32'h21, 32'h123456AB, 1'b0, 32'd0, 1);
    push_wr(30'd8, 4'b1100, 32'h56785678);
    issue("sh22", 1'b1, 3'b001, 32'h22, 32'h00005678, 1'b0, 32'd0, 1);
    issue("lw20", 1'b0, 3'b010, 32'h20, 32'd0, 1'b0, 32'h5678AB00, 2);

`ifdef LSU_MISALIGN_SPLIT_EN
    push_wr(30'd4, 4'b1110, 32'h22334400);
    push_wr(30'd5, 4'b0001, 32'h00000011);
    issue("sw11", 1'b1, 3'b010, 32'h11, 32'h11223344, 1'b0, 32'd0, 2);
    issue("lw11", 1'b0, 3'b010, 32'h11, 32'd0, 1'b0, 32'h11223344, 3);
    issue("lh13", 1'b0, 3'b001, 32'h13, 32'd0, 1'b0, 32'h00001122, 3);
    issue("lhu11", 1'b0, 3'b101, 32'h11, 32'd0, 1'b0, 32'h00003344, 3);
`else
    issue("lw11", 1'b0, 3'b010, 32'h11, 32'd0, 1'b1, 32'd0, 1);
    issue("sw11", 1'b1, 3'b010, 32'h11, 32'h11223344, 1'b1, 32'd0, 1);
    issue("lh13", 1'b0, 3'b001, 32'h13, 32'd0, 1'b1, 32'd0, 1);
    issue("sh11", 1'b1, 3'b001, 32'h11, 32'h5555, 1'b1, 32'd0, 1);
    issue("lw10_after", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 2);
`endif

    issue("t111", 1'b0, 3'b111, 32'h10, 32'd0, 1'b1, 32'd0, 1);
    issue("t011", 1'b1, 3'b011, 32'h10, 32'hFFFF, 1'b1, 32'd0, 1);
    issue("t110", 1'b0, 3'b110, 32'h10, 32'd0, 1'b1, 32'd0, 1);
    issue("bu_store", 1'b1, 3'b100, 32'h10, 32'hFF, 1'b1, 32'd0, 1);

    push_wr(30'd12, 4'b0001, 32'h77777777);
    issue("sb30", 1'b1, 3'b000, 32'h30, 32'h00000077, 1'b0, 32'd0, 1);
    issue("b2b_lw30", 1'b0, 3'b010, 32'h30, 32'd0, 1'b0, 32'h00000077, 2);
    issue("b2b_lw20", 1'b0, 3'b010, 32'h20, 32'd0, 1'b0, 32'h5678AB00, 2);
    drain();

    // Reset while a store is in its ACCESS cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_type = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", {60'd0, mem_we}, 64'd0);
    @(negedge clk);
    chk("rst_mid_ram", {32'd0, ram[16]}, 64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);

    for (int k = 0; k < 6; k++) begin
      waddr = $urandom_range(17, 63);
      wd = $urandom;
      for (int j = 0; j < 4; j++) bm[waddr*4 + j] = wd[8*j +: 8];
      push_wr(30'(waddr), 4'b1111, wd);
      issue("rnd_sw", 1'b1, 3'b010, 32'(waddr*4), wd, 1'b0, 32'd0, 1);
      ts = $urandom_range(0, 3);
      o = $urandom_range(0, 3);
      case (ts)
        0: t = 3'b000;
        1: t = 3'b100;
        2: t = 3'b001;
        default: t = 3'b101;
      endcase
      if (t[0]) o = o & 2;
      issue("rnd_ld", 1'b0, t, 32'(waddr*4 + o), 32'd0, 1'b0, ref_load(t, waddr*4 + o), 2);
      issue("rnd_lw", 1'b0, 3'b010, 32'(waddr*4), 32'd0, 1'b0, ref_load(3'b010, waddr*4), 2);
    end

    drain();
    repeat (3) @(negedge clk);
    chk("rq_empty", 64'(rq.size()), 64'd0);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
